// File: rtl/inventory_stream.sv
// -----------------------------------------------------------------------------
// inventory_stream
// Streaming freshness checker. A table of inclusive ID ranges is loaded over a
// ready/valid channel; item IDs are then classified one at a time by scanning
// the table sequentially (first hit wins), and fresh items are counted.
//
// Optional feature macro: INVENTORY_HIT_INDEX_EN adds output res_idx, the
// lowest matching range index of a fresh item (0 on a miss).
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   restart             synchronous clear of table/count, back to LOAD
//   rng_valid/ready     range load handshake; rng_lo, rng_hi, rng_last
//   item_valid/ready    item handshake; item_id, item_last
//   res_valid/fresh     one-cycle result pulse per classified item
//   count, count_sat    saturating fresh count and its sticky overflow flag
//   nranges             number of ranges loaded
//   done                final item has been classified
// -----------------------------------------------------------------------------
module inventory_stream #(
    parameter int unsigned ID_W       = 50,
    parameter int unsigned MAX_RANGES = 256,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned IDX_W     = (MAX_RANGES > 1) ? $clog2(MAX_RANGES) : 1,
    localparam int unsigned NR_W      = $clog2(MAX_RANGES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic             rng_valid,
    output logic             rng_ready,
    input  logic [ID_W-1:0]  rng_lo,
    input  logic [ID_W-1:0]  rng_hi,
    input  logic             rng_last,
    input  logic             item_valid,
    output logic             item_ready,
    input  logic [ID_W-1:0]  item_id,
    input  logic             item_last,
    output logic             res_valid,
    output logic             res_fresh,
`ifdef INVENTORY_HIT_INDEX_EN
    output logic [IDX_W-1:0] res_idx,
`endif
    output logic [CNT_W-1:0] count,
    output logic             count_sat,
    output logic [NR_W-1:0]  nranges,
    output logic             done
);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_WAIT = 2'd1,
        S_SCAN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ID_W-1:0]   r_lo [MAX_RANGES];
    logic [ID_W-1:0]   r_hi [MAX_RANGES];
    logic [NR_W-1:0]   r_nranges;
    logic [IDX_W-1:0]  r_j;
    logic [ID_W-1:0]   r_item_id;
    logic              r_item_last;
    logic              r_res_valid;
    logic              r_res_fresh;
    logic [CNT_W-1:0]  r_count;
    logic              r_count_sat;
    logic              r_done;
`ifdef INVENTORY_HIT_INDEX_EN
    logic [IDX_W-1:0]  r_res_idx;
`endif

    logic              w_rng_hs;
    logic              w_load_end;
    logic              w_item_hs;
    logic [ID_W-1:0]   w_lo_j;
    logic [ID_W-1:0]   w_hi_j;
    logic              w_hit;
    logic              w_scan_end;

    // Handshakes and scan compare
    assign w_rng_hs   = rng_valid && rng_ready;
    // Filling the last table slot ends the load even without rng_last
    assign w_load_end = w_rng_hs && (rng_last || (r_nranges == NR_W'(MAX_RANGES - 1)));
    assign w_item_hs  = item_valid && item_ready;
    assign w_lo_j     = r_lo[r_j];
    assign w_hi_j     = r_hi[r_j];
    // An empty table never hits; lo>hi can never satisfy both bounds
    assign w_hit      = (r_nranges != '0) && (r_item_id >= w_lo_j) && (r_item_id <= w_hi_j);
    // j+1 >= nranges also covers the empty table (single miss cycle)
    assign w_scan_end = (r_state == S_SCAN) &&
                        (w_hit || ((NR_W'(r_j) + NR_W'(1)) >= r_nranges));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; restart has top priority
    always_comb begin
        w_state_nxt = r_state;
        if (restart) begin
            w_state_nxt = S_LOAD;
        end else begin
            case (r_state)
                S_LOAD: if (w_load_end) w_state_nxt = S_WAIT;
                S_WAIT: if (w_item_hs)  w_state_nxt = S_SCAN;
                S_SCAN: if (w_scan_end) w_state_nxt = r_item_last ? S_DONE : S_WAIT;
                S_DONE: w_state_nxt = S_DONE;
                default: w_state_nxt = S_LOAD;
            endcase
        end
    end

    // Ready outputs are pure state decodes
    always_comb begin
        rng_ready  = 1'b0;
        item_ready = 1'b0;
        case (r_state)
            S_LOAD: rng_ready  = 1'b1;
            S_WAIT: item_ready = 1'b1;
            default: ;
        endcase
    end

    // Range table storage; contents beyond nranges are never consulted
    always_ff @(posedge clk) begin
        if (!restart && w_rng_hs) begin
            r_lo[IDX_W'(r_nranges)] <= rng_lo;
            r_hi[IDX_W'(r_nranges)] <= rng_hi;
        end
    end

    // Datapath: table fill, item latch, scan index, results and count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_nranges   <= '0;
            r_j         <= '0;
            r_item_id   <= '0;
            r_item_last <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_fresh <= 1'b0;
            r_count     <= '0;
            r_count_sat <= 1'b0;
            r_done      <= 1'b0;
`ifdef INVENTORY_HIT_INDEX_EN
            r_res_idx   <= '0;
`endif
        end else if (restart) begin
            r_nranges   <= '0;
            r_res_valid <= 1'b0;
            r_count     <= '0;
            r_count_sat <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            if (w_rng_hs) begin
                r_nranges <= r_nranges + NR_W'(1);
            end
            if (w_item_hs) begin
                r_item_id   <= item_id;
                r_item_last <= item_last;
                r_j         <= '0;
            end
            if ((r_state == S_SCAN) && !w_scan_end) begin
                r_j <= r_j + IDX_W'(1);
            end
            if (w_scan_end) begin
                r_res_valid <= 1'b1;
                r_res_fresh <= w_hit;
`ifdef INVENTORY_HIT_INDEX_EN
                r_res_idx   <= w_hit ? r_j : '0;
`endif
                if (w_hit) begin
                    if (r_count == {CNT_W{1'b1}}) begin
                        r_count_sat <= 1'b1;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                if (r_item_last) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign res_valid = r_res_valid;
    assign res_fresh = r_res_fresh;
    assign count     = r_count;
    assign count_sat = r_count_sat;
    assign nranges   = r_nranges;
    assign done      = r_done;
`ifdef INVENTORY_HIT_INDEX_EN
    assign res_idx   = r_res_idx;
`endif

endmodule

// File: tb/tb_inventory_stream.sv
// -----------------------------------------------------------------------------
// tb_inventory_stream
// Self-checking bench for inventory_stream with a queue-based reference model
// (first matching range by linear search, latency from the hit index).
// -----------------------------------------------------------------------------
module tb_inventory_stream;

    localparam int unsigned ID_W       = 50;
    localparam int unsigned MAX_RANGES = 8;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned NR_W       = 4;
    localparam int          CNT_MAX    = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic             restart;
    logic             rng_valid;
    logic             rng_ready;
    logic [ID_W-1:0]  rng_lo;
    logic [ID_W-1:0]  rng_hi;
    logic             rng_last;
    logic             item_valid;
    logic             item_ready;
    logic [ID_W-1:0]  item_id;
    logic             item_last;
    logic             res_valid;
    logic             res_fresh;
    logic [CNT_W-1:0] count;
    logic             count_sat;
    logic [NR_W-1:0]  nranges;
    logic             done;
`ifdef INVENTORY_HIT_INDEX_EN
    logic [IDX_W-1:0] res_idx;
`endif

    inventory_stream #(
        .ID_W       (ID_W),
        .MAX_RANGES (MAX_RANGES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .restart    (restart),
        .rng_valid  (rng_valid),
        .rng_ready  (rng_ready),
        .rng_lo     (rng_lo),
        .rng_hi     (rng_hi),
        .rng_last   (rng_last),
        .item_valid (item_valid),
        .item_ready (item_ready),
        .item_id    (item_id),
        .item_last  (item_last),
        .res_valid  (res_valid),
        .res_fresh  (res_fresh),
`ifdef INVENTORY_HIT_INDEX_EN
        .res_idx    (res_idx),
`endif
        .count      (count),
        .count_sat  (count_sat),
        .nranges    (nranges),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [ID_W-1:0] m_lo[$];
    logic [ID_W-1:0] m_hi[$];
    int              m_count;
    bit              m_sat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_k(input logic [ID_W-1:0] id);
        for (int i = 0; i < m_lo.size(); i++) begin
            if (m_lo[i] <= id && id <= m_hi[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_clear();
        m_lo.delete();
        m_hi.delete();
        m_count = 0;
        m_sat   = 1'b0;
    endtask

    // All tasks start and end #1 after a rising edge
    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        model_clear();
        @(negedge clk);
        check("rst_nranges", 64'(nranges), 64'd0);
        check("rst_count",   64'(count),   64'd0);
        check("rst_rngrdy",  64'(rng_ready), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic send_range(input logic [ID_W-1:0] lo, input logic [ID_W-1:0] hi,
                              input bit last, input int gap);
        int t;
        bit ok;
        repeat (gap) begin @(posedge clk); #1; end
        rng_valid = 1'b1;
        rng_lo    = lo;
        rng_hi    = hi;
        rng_last  = last;
        t  = 0;
        ok = 1'b0;
        while (!ok && t < 50) begin
            @(negedge clk);
            ok = rng_ready;
            @(posedge clk); #1;
            t++;
        end
        rng_valid = 1'b0;
        rng_last  = 1'b0;
        if (!ok) check("rng_hs_timeout", 64'd0, 64'd1);
        else begin
            m_lo.push_back(lo);
            m_hi.push_back(hi);
        end
    endtask

    task automatic check_loaded();
        @(negedge clk);
        check("load_nranges", 64'(nranges), 64'(m_lo.size()));
        check("load_rngrdy",  64'(rng_ready), 64'd0);
        check("load_itemrdy", 64'(item_ready), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic accept_item(input logic [ID_W-1:0] id, input bit last, input int gap,
                               output bit ok);
        int t;
        repeat (gap) begin @(posedge clk); #1; end
        item_valid = 1'b1;
        item_id    = id;
        item_last  = last;
        t  = 0;
        ok = 1'b0;
        while (!ok && t < 50) begin
            @(negedge clk);
            ok = item_ready;
            @(posedge clk); #1;
            t++;
        end
        item_valid = 1'b0;
        item_last  = 1'b0;
        if (!ok) check("item_hs_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_item(input logic [ID_W-1:0] id, input bit last, input int gap);
        int k, n, exp_lat, lat;
        bit ok;
        k = model_k(id);
        n = m_lo.size();
        exp_lat = (k >= 0) ? k + 2 : ((n == 0) ? 2 : n + 1);
        if (k >= 0) begin
            if (m_count == CNT_MAX) m_sat = 1'b1;
            else m_count++;
        end
        accept_item(id, last, gap, ok);
        if (!ok) return;
        lat = 0;
        for (int c = 1; c <= int'(MAX_RANGES) + 4; c++) begin
            @(negedge clk);
            if (res_valid) begin
                lat = c;
                break;
            end
        end
        if (lat == 0) begin
            check("res_timeout", 64'd0, 64'd1);
            @(posedge clk); #1;
            return;
        end
        check("latency",   64'(lat),       64'(exp_lat));
        check("res_fresh", 64'(res_fresh), 64'(k >= 0));
        check("count",     64'(count),     64'(m_count));
        check("count_sat", 64'(count_sat), 64'(m_sat));
        check("done",      64'(done),      64'(last));
        check("item_rdy",  64'(item_ready), 64'(!last));
`ifdef INVENTORY_HIT_INDEX_EN
        check("res_idx",   64'(res_idx),   64'((k >= 0) ? k : 0));
`endif
        @(negedge clk);
        check("res_pulse", 64'(res_valid), 64'd0);
        if (last) begin
            check("done_rngrdy",  64'(rng_ready),  64'd0);
            check("done_itemrdy", 64'(item_ready), 64'd0);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rngrdy"},  64'(rng_ready),  64'd1);
        check({tag, "_itemrdy"}, 64'(item_ready), 64'd0);
        check({tag, "_resv"},    64'(res_valid),  64'd0);
        check({tag, "_fresh"},   64'(res_fresh),  64'd0);
        check({tag, "_count"},   64'(count),      64'd0);
        check({tag, "_sat"},     64'(count_sat),  64'd0);
        check({tag, "_nr"},      64'(nranges),    64'd0);
        check({tag, "_done"},    64'(done),       64'd0);
    endtask

    initial begin
        logic [ID_W-1:0] big;
        bit ok;
        int bad;
        reset = 1'b1; restart = 1'b0;
        rng_valid = 1'b0; rng_lo = '0; rng_hi = '0; rng_last = 1'b0;
        item_valid = 1'b0; item_id = '0; item_last = 1'b0;
        model_clear();
        #3;
        check_reset_vals("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Example puzzle
        send_range(50'd3,  50'd5,  1'b0, 0);
        send_range(50'd10, 50'd14, 1'b0, 0);
        send_range(50'd16, 50'd20, 1'b0, 0);
        send_range(50'd12, 50'd18, 1'b1, 0);
        check_loaded();
        send_item(50'd1,  1'b0, 0);
        send_item(50'd5,  1'b0, 0);
        send_item(50'd8,  1'b0, 0);
        send_item(50'd11, 1'b0, 0);
        send_item(50'd17, 1'b0, 0);
        send_item(50'd32, 1'b1, 0);
        check("puzzle_count", 64'(count), 64'd3);
        check("puzzle_done",  64'(done),  64'd1);

        // Full-width bounds and an inverted range
        do_restart();
        big = {ID_W{1'b1}};
        send_range(big - 50'd1, big, 1'b0, 0);
        send_range(50'd9, 50'd7, 1'b1, 0);
        check_loaded();
        send_item(big,          1'b0, 0);
        send_item(big - 50'd2,  1'b0, 0);
        send_item(50'd8,        1'b1, 0);

        // Single never-matching range
        do_restart();
        send_range(50'd1, 50'd0, 1'b1, 0);
        check_loaded();
        send_item(50'd0, 1'b0, 0);
        send_item(50'd1, 1'b1, 1);

        // Table fill without rng_last ends the load
        do_restart();
        for (int i = 0; i < int'(MAX_RANGES); i++)
            send_range(50'(i * 10), 50'(i * 10 + 3), 1'b0, 0);
        check_loaded();
        send_item(50'd72, 1'b0, 0);
        send_item(50'd4,  1'b0, 0);
        send_item(50'd1,  1'b1, 0);

        // Saturation
        do_restart();
        send_range(50'd0, 50'd100, 1'b1, 0);
        check_loaded();
        for (int i = 0; i < 9; i++) send_item(50'd50, (i == 8), 0);
        check("sat_count", 64'(count),     64'(CNT_MAX));
        check("sat_flag",  64'(count_sat), 64'd1);

        // Restart during scan discards the in-flight item
        do_restart();
        for (int i = 0; i < int'(MAX_RANGES); i++)
            send_range(50'(i * 10), 50'(i * 10), 1'b0, 0);
        check_loaded();
        accept_item(50'd1000, 1'b0, 0, ok);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (res_valid) bad++;
        end
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        model_clear();
        @(negedge clk);
        check("mid_rngrdy", 64'(rng_ready), 64'd1);
        check("mid_nr",     64'(nranges),   64'd0);
        check("mid_count",  64'(count),     64'd0);
        repeat (12) begin
            @(negedge clk);
            if (res_valid) bad++;
        end
        check("mid_no_res", 64'(bad), 64'd0);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a load
        send_range(50'd5, 50'd6, 1'b0, 0);
        send_range(50'd7, 50'd8, 1'b0, 0);
        #3 reset = 1'b1;
        #1 check_reset_vals("areset");
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        @(posedge clk); #1;

        // Randomized tables and items with gapped valids
        for (int t = 0; t < 15; t++) begin
            int n, ni;
            do_restart();
            n = $urandom_range(1, MAX_RANGES);
            for (int i = 0; i < n; i++) begin
                logic [ID_W-1:0] lo, hi;
                lo = 50'($urandom_range(0, 60));
                hi = 50'($urandom_range(0, 8)) + lo;
                if ($urandom_range(0, 5) == 0) hi = lo - 50'd1;
                send_range(lo, hi, (i == n - 1) && (n < int'(MAX_RANGES) || $urandom_range(0, 1) == 1),
                           $urandom_range(0, 2));
            end
            check_loaded();
            ni = $urandom_range(1, 8);
            for (int i = 0; i < ni; i++)
                send_item(50'($urandom_range(0, 80)), (i == ni - 1), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/inventory_stream.md
# inventory_stream

- Streaming, parametrised freshness checker for the Day 5 inventory.
- Loads a table of inclusive ID ranges over a ready/valid channel, then accepts item IDs one at a time on a second channel.
- Scans the table sequentially per item with early exit on the first hit, and keeps a running count of fresh items.
- Replaces the fixed-array, fixed-size inventory block with handshaked, re-startable, depth/width-generic hardware.

## Interface
Parameters:
- ID_W, 50, width of item IDs and range bounds
- MAX_RANGES, 256, range table depth (≥1); IDX_W = $clog2(MAX_RANGES) (min 1), NR_W = $clog2(MAX_RANGES+1)
- CNT_W, 16, fresh-count width

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- restart  in  1  synchronous pulse; clears table and count, returns to LOAD
- rng_valid / rng_ready  in / out  1 / 1  range load handshake
- rng_lo, rng_hi  in  ID_W  inclusive bounds
- rng_last  in  1  marks final range
- item_valid / item_ready  in / out  1 / 1  item handshake
- item_id  in  ID_W  item to classify
- item_last  in  1  marks final item
- res_valid  out  1  one-cycle pulse per classified item
- res_fresh  out  1  item hit ≥1 range, valid with res_valid
- count  out  CNT_W  fresh items since restart
- count_sat  out  1  sticky, count saturated
- nranges  out  NR_W  ranges loaded
- done  out  1  final item classified

## Operation
- FSM states: LOAD, WAIT_ITEM, SCAN, DONE.
- LOAD:
  - rng_ready=1.
  - Each handshake writes the table at index nranges and increments nranges.
  - Leaves to WAIT_ITEM on a handshake with rng_last=1, or on the handshake that makes nranges==MAX_RANGES (treated as last).
- WAIT_ITEM: item_ready=1; a handshake latches item_id and item_last, clears scan index j, enters SCAN.
- SCAN:
  - One comparison per cycle: hit iff rng_lo[j] ≤ id ≤ rng_hi[j], unsigned, full ID_W.
  - A range with lo>hi never matches.
  - Terminates on first hit, or after comparing index nranges-1 (miss).
  - nranges==0: one SCAN cycle, result miss.
- On termination edge:
  - res_valid/res_fresh registered.
  - count += hit, saturating at 2^CNT_W−1; count_sat sets on an increment attempted at all-ones.
  - Next state is DONE if the latched item_last=1, else WAIT_ITEM.
- DONE: all readies 0, done=1, outputs held until restart/reset.
- restart (any state, highest priority, synchronous): nranges=0, count=0, count_sat=0, done=0, res_valid=0, state=LOAD. Any in-flight item is discarded with no result.
- Ranges may overlap; an item is counted at most once.

## Timing
- Reset values:
  - state=LOAD, rng_ready=1 (combinational from state)
  - item_ready=0, res_valid=0, res_fresh=0
  - count=0, count_sat=0, nranges=0, done=0
- rng_ready and item_ready are pure decodes of the state; no combinational path from the valid inputs.
- Item accepted at edge E0: range j compared in cycle j+1 after E0.
- Hit at index k: res_valid high in cycle k+2, count updated at the same edge.
- Miss: res_valid high in cycle nranges+1 (cycle 2 if nranges=0).
- item_ready reasserts in the same cycle as res_valid, so back-to-back items are possible. Per-item cost: k+2 cycles on hit, nranges+1 on miss.
- First item accepted no earlier than the cycle after the last range handshake.
- done rises in the cycle res_valid pulses for the last item.

## Configuration
- INVENTORY_HIT_INDEX_EN defined:
  - Adds output res_idx [IDX_W-1:0], the lowest matching range index, valid with res_valid when res_fresh=1.
  - res_idx is 0 on a miss and at reset.
- Undefined: port and its register absent; all other behaviour identical.

## Test plan
- Example puzzle:
  - Ranges 3-5, 10-14, 16-20, 12-18 (last on 4th); items 1, 5, 8, 11, 17, 32 (last on 32).
  - Expect res_fresh 0,1,0,1,1,0; count=3; done=1.
  - With INVENTORY_HIT_INDEX_EN: res_idx for 5, 11, 17 = 0, 1, 2.
- Latency:
  - Same table; item 17 accepted at E0 → res_valid exactly 4 cycles later (k=2).
  - Item 32 → res_valid exactly 5 cycles later (miss, nranges=4).
- Bounds/degenerate:
  - ID_W=50, range 0x3FFFFFFFFFFFE–0x3FFFFFFFFFFFF, range 9–7: items 0x3FFFFFFFFFFFF → fresh, 8 → miss.
  - Zero ranges (restart then rng_last with lo=1,hi=0 loads one never-matching range; also MAX_RANGES=1 auto-exit after one handshake without rng_last).
- Saturation: CNT_W=2, range 0–100, five items of 50 → count=3, count_sat=1 after 4th.
- Restart mid-SCAN:
  - MAX_RANGES=8, 8 ranges, restart at scan cycle 3 → no res_valid for that item, count=0, nranges=0, rng_ready=1 next cycle.
  - Async reset asserted mid-LOAD → all outputs at reset values immediately.
- Backpressure: item_valid toggled randomly and rng_valid gapped → results identical to the ungapped run; no handshake ever occurs outside LOAD/WAIT_ITEM.
